// File: rtl/brick_raster_if.sv
// Pixel-plotter request/response bundle for brick_raster.
// Master drives the brick request; slave returns the pixel stream.
interface brick_raster_if;
    logic       draw;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic [2:0] colour_in;
    logic       plot;
    logic [9:0] x_out;
    logic [9:0] y_out;
    logic [2:0] colour_out;
    logic       busy;
    logic       done;

    modport master (
        output draw, x_in, y_in, colour_in,
        input  plot, x_out, y_out, colour_out, busy, done
    );

    modport slave (
        input  draw, x_in, y_in, colour_in,
        output plot, x_out, y_out, colour_out, busy, done
    );
endinterface

// File: rtl/brick_raster.sv
// Rasterises one solid brick per draw request, one pixel per cycle,
// row-major, clipping pixels that fall outside the visible screen.
module brick_raster #(
    parameter int BRICK_W  = 10,
    parameter int BRICK_H  = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic         clk,
    input  logic         resetn,
    brick_raster_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_DONE
    } state_t;

    localparam logic [9:0]  CX_LAST = 10'(BRICK_W - 1);
    localparam logic [9:0]  CY_LAST = 10'(BRICK_H - 1);
    localparam logic [10:0] X_LIM   = 11'(SCREEN_W);
    localparam logic [10:0] Y_LIM   = 11'(SCREEN_H);

    state_t     state_q, state_d;
    logic [9:0] cx_q, cx_d;
    logic [9:0] cy_q, cy_d;
    logic [9:0] xl_q, xl_d;
    logic [9:0] yl_q, yl_d;
    logic [2:0] cl_q, cl_d;

    logic [9:0] px;
    logic [9:0] py;

    // State, counters and latched brick parameters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            cl_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            cl_q    <= cl_d;
        end
    end

    // Next state; counters freeze on the last pixel so the
    // pixel outputs keep showing it until the next brick starts.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        cl_d    = cl_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.draw) begin
                    xl_d    = bus.x_in;
                    yl_d    = bus.y_in;
                    cl_d    = bus.colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_PLOT;
                end
            end
            S_PLOT: begin
                if (cx_q == CX_LAST) begin
                    if (cy_q == CY_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cx_d = '0;
                        cy_d = cy_q + 10'd1;
                    end
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign px = xl_q + cx_q;
    assign py = yl_q + cy_q;

    assign bus.x_out      = px;
    assign bus.y_out      = py;
    assign bus.colour_out = cl_q;
    assign bus.busy       = (state_q == S_PLOT);
    assign bus.done       = (state_q == S_DONE);
    assign bus.plot       = (state_q == S_PLOT)
                          && ({1'b0, px} < X_LIM)
                          && ({1'b0, py} < Y_LIM);
endmodule

// File: tb/tb_brick_raster.sv
// Self-checking bench for brick_raster: directed and random bricks
// compared cycle by cycle against a row/column reference model.
module tb_brick_raster;
    localparam int W  = 10;
    localparam int H  = 5;
    localparam int SW = 160;
    localparam int SH = 120;

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_total;

    logic [9:0] last_x;
    logic [9:0] last_y;
    logic [2:0] last_c;

    brick_raster_if bus ();

    brick_raster #(
        .BRICK_W (W),
        .BRICK_H (H),
        .SCREEN_W(SW),
        .SCREEN_H(SH)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] observed();
        return {bus.busy, bus.plot, bus.done,
                bus.x_out, bus.y_out, bus.colour_out};
    endfunction

    task automatic drive(input logic d, input logic [9:0] x,
                         input logic [9:0] y, input logic [2:0] c);
        bus.draw      = d;
        bus.x_in      = x;
        bus.y_in      = y;
        bus.colour_in = c;
    endtask

    // Idle-cycle check followed by a draw request.
    task automatic start_brick(input logic [9:0] x, input logic [9:0] y,
                               input logic [2:0] c);
        logic [25:0] exp_v;
        @(negedge clk);
        exp_v = {3'b000, last_x, last_y, last_c};
        n_total++;
        if (observed() !== exp_v)
            $display("FAIL idle obs=%h exp=%h", observed(), exp_v);
        else
            n_pass++;
        drive(1'b1, x, y, c);
    endtask

    // Walks the brick's pixels (first npix of them) in row-major
    // order; optionally checks the done cycle afterwards.
    task automatic check_brick(input logic [9:0] x, input logic [9:0] y,
                               input logic [2:0] c, input bit hold,
                               input int npix, input bit chk_done,
                               input bit draw_at_done,
                               output int nplot);
        logic [25:0] exp_v;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic        ep;
        int          idx;
        nplot = 0;
        idx   = 0;
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                if (idx < npix) begin
                    @(negedge clk);
                    ex    = 10'((int'(x) + k) % 1024);
                    ey    = 10'((int'(y) + r) % 1024);
                    ep    = (int'(ex) < SW) && (int'(ey) < SH);
                    exp_v = {1'b1, ep, 1'b0, ex, ey, c};
                    n_total++;
                    if (observed() !== exp_v)
                        $display("FAIL pixel r=%0d k=%0d obs=%h exp=%h",
                                 r, k, observed(), exp_v);
                    else
                        n_pass++;
                    if (bus.plot === 1'b1) nplot++;
                    last_x = ex;
                    last_y = ey;
                    last_c = c;
                    if (hold) bus.x_in = 10'($urandom);
                    else      bus.draw = 1'b0;
                end
                idx++;
            end
        end
        if (chk_done) begin
            @(negedge clk);
            exp_v = {3'b001, last_x, last_y, last_c};
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL done obs=%h exp=%h", observed(), exp_v);
            else
                n_pass++;
            if (draw_at_done)
                drive(1'b1, 10'd300, 10'd300, 3'd7);
        end
    endtask

    task automatic check_count(input string nm, input int got,
                               input int want);
        n_total++;
        if (got !== want)
            $display("FAIL %s plots=%0d want=%0d", nm, got, want);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b1, 10'd77, 10'd33, 3'd5);
        repeat (3) @(negedge clk);
        n_total++;
        if (observed() !== 26'd0)
            $display("FAIL reset obs=%h exp=0", observed());
        else
            n_pass++;
        bus.draw = 1'b0;
        resetn   = 1'b1;
        last_x   = '0;
        last_y   = '0;
        last_c   = '0;
    endtask

    task automatic test_basic();
        int np;
        start_brick(10'd20, 10'd10, 3'b100);
        check_brick(10'd20, 10'd10, 3'b100, 0, W * H, 1, 0, np);
        check_count("basic", np, 50);
    endtask

    task automatic test_clip();
        int np;
        start_brick(10'd155, 10'd118, 3'd2);
        check_brick(10'd155, 10'd118, 3'd2, 0, W * H, 1, 0, np);
        check_count("clip", np, 10);
    endtask

    task automatic test_wrap();
        int np;
        start_brick(10'd1020, 10'd0, 3'd6);
        check_brick(10'd1020, 10'd0, 3'd6, 0, W * H, 1, 0, np);
        check_count("wrap", np, 30);
    endtask

    task automatic test_back_to_back();
        int np;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        for (int b = 0; b < 3; b++) begin
            x = 10'($urandom_range(0, 150));
            y = 10'($urandom_range(0, 115));
            c = 3'($urandom);
            start_brick(x, y, c);
            check_brick(x, y, c, 1, W * H, 1, 0, np);
            check_count("b2b", np, 50);
        end
        bus.draw = 1'b0;
    endtask

    task automatic test_reset_mid();
        int np;
        start_brick(10'd40, 10'd50, 3'd3);
        check_brick(10'd40, 10'd50, 3'd3, 0, 20, 0, 0, np);
        #2 resetn = 1'b0;
        #1;
        n_total++;
        if (observed() !== 26'd0)
            $display("FAIL rst_now obs=%h exp=0", observed());
        else
            n_pass++;
        last_x = '0;
        last_y = '0;
        last_c = '0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (observed() !== 26'd0)
                $display("FAIL rst_hold obs=%h exp=0", observed());
            else
                n_pass++;
        end
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 10'd0, 10'd0, 3'd1);
        check_brick(10'd0, 10'd0, 3'd1, 0, W * H, 1, 0, np);
        check_count("after_rst", np, 50);
    endtask

    task automatic test_draw_in_done();
        int np;
        start_brick(10'd100, 10'd100, 3'd5);
        check_brick(10'd100, 10'd100, 3'd5, 0, W * H, 1, 1, np);
        check_count("done_draw", np, 50);
        start_brick(10'd8, 10'd9, 3'd2);
        check_brick(10'd8, 10'd9, 3'd2, 0, W * H, 1, 0, np);
        check_count("after_done", np, 50);
    endtask

    task automatic test_random();
        int np;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        for (int b = 0; b < 8; b++) begin
            x = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(140, 1023))
                                            : 10'($urandom_range(0, 170));
            y = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(110, 1023))
                                            : 10'($urandom_range(0, 125));
            c = 3'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_brick(x, y, c);
            check_brick(x, y, c, 0, W * H, 1, 0, np);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        drive(1'b0, '0, '0, '0);
        test_reset();
        test_basic();
        test_clip();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_draw_in_done();
        test_random();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/brick_raster.md
BRICK_RASTER -- requirements
Module: brick_raster

Interface
REQ-001 Parameter BRICK_W, default 10, brick width in pixels.
REQ-002 Parameter BRICK_H, default 5, brick height in pixels.
REQ-003 Parameter SCREEN_W, default 160, visible columns; x at or above this value is off-screen.
REQ-004 Parameter SCREEN_H, default 120, visible rows; y at or above this value is off-screen.
REQ-005 Port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 Port resetn, input, 1, reset, asynchronous and active-low.
REQ-007 Port draw, input, 1, request strobe to rasterise one brick.
REQ-008 Port x_in, input, 10, brick top-left column.
REQ-009 Port y_in, input, 10, brick top-left row.
REQ-010 Port colour_in, input, 3, brick fill colour.
REQ-011 Port plot, output, 1, pixel write enable to the VGA adapter.
REQ-012 Port x_out, output, 10, pixel column.
REQ-013 Port y_out, output, 10, pixel row.
REQ-014 Port colour_out, output, 3, pixel colour.
REQ-015 Port busy, output, 1, high while a brick is being rasterised.
REQ-016 Port done, output, 1, one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly three states: S_IDLE, S_PLOT and S_DONE.
REQ-018 In S_IDLE, a rising edge with draw=1 SHALL latch x_in, y_in and colour_in, clear the column and row counters cx and cy, and enter S_PLOT.
REQ-019 In S_IDLE with draw=0, the FSM SHALL remain in S_IDLE.
REQ-020 draw SHALL be ignored in S_PLOT and S_DONE; latched values SHALL NOT change there.
REQ-021 The state SHALL be S_PLOT for exactly BRICK_W*BRICK_H consecutive cycles, one pixel per cycle.
REQ-022 The pixel order SHALL be row-major: cx runs 0..BRICK_W-1, then wraps to 0 and increments cy.
REQ-023 On the S_PLOT cycle with cx=BRICK_W-1 and cy=BRICK_H-1, the next state SHALL be S_DONE.
REQ-024 In S_PLOT, the outputs SHALL be x_out=x_lat+cx, y_out=y_lat+cy (10-bit, wrapping modulo 1024) and colour_out=colour_lat.
REQ-025 plot SHALL be 1 in S_PLOT only when x_out<SCREEN_W and y_out<SCREEN_H; otherwise plot=0, but the cycle is still consumed (clipping).
REQ-026 busy SHALL be 1 exactly when the state is S_PLOT.
REQ-027 done SHALL be 1 exactly when the state is S_DONE, which lasts one cycle, followed unconditionally by S_IDLE.
REQ-028 Outside S_PLOT, plot SHALL be 0; x_out, y_out and colour_out SHALL hold their last values.
REQ-029 Latency: draw sampled on edge N gives the first plot on cycle N+1, the last plot on cycle N+BRICK_W*BRICK_H, and done on the following cycle.
REQ-030 A new draw SHALL be accepted no earlier than the edge after done; back-to-back brick rate is BRICK_W*BRICK_H+2 cycles.
REQ-031 All outputs SHALL be driven combinationally from registered state and counters only; no output SHALL depend on the current draw, x_in, y_in or colour_in.

Reset
REQ-032 resetn=0 SHALL immediately force S_IDLE, cx=cy=0, latched values=0, plot=0, busy=0, done=0, x_out=y_out=0 and colour_out=0.
REQ-033 Reset asserted mid-S_PLOT SHALL abort the brick with no further plot and no done pulse.
REQ-034 After resetn deasserts, the first draw SHALL be accepted on the first rising edge.

Verification
REQ-035 Draw (x=20, y=10, col=3'b100) from idle -> 50 plot pulses covering x 20..29 and y 10..14 in row-major order, colour 4, busy high for 50 cycles, then exactly one done pulse.
REQ-036 Draw at (x=155, y=118) -> 50 busy cycles, plot only for x 155..159 and y 118..119 (10 pixels), done on cycle 51.
REQ-037 draw held high continuously -> bricks repeat every 52 cycles; changing x_in mid-brick does not alter the current brick's pixels.
REQ-038 resetn pulsed low on the 20th plot cycle -> plot, busy and done all 0 immediately; no done pulse; the next draw renders a full brick.
REQ-039 Draw at (x=1020, y=0) -> x_out wraps through 0..5, and only x 0..5 plot (30 pixels over 5 rows); done still asserts.
REQ-040 draw asserted during the S_DONE cycle -> ignored; the state returns to S_IDLE and the following draw is accepted.
